// File: rtl/gpio_bank.sv
// Multi-port GPIO controller on the simple register bus: per-port DIR/OUT/IE/IS/EDGE registers,
// synchronised pin inputs, and sticky per-pin edge interrupts combined into one irq line.
module gpio_bank #(
  parameter int unsigned N_PORTS     = 3,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  input  logic [N_PORTS*WIDTH-1:0]   gpio_in,
  output logic [N_PORTS*WIDTH-1:0]   gpio_out,
  output logic [N_PORTS*WIDTH-1:0]   gpio_oe,
  output logic                       irq
);

  localparam int unsigned PW = ADDR_W - 3;

  localparam logic [2:0] RegDir  = 3'd0;
  localparam logic [2:0] RegOut  = 3'd1;
  localparam logic [2:0] RegIn   = 3'd2;
  localparam logic [2:0] RegIe   = 3'd3;
  localparam logic [2:0] RegIs   = 3'd4;
  localparam logic [2:0] RegEdge = 3'd5;

  logic [PW-1:0] port_sel;
  logic [2:0]    reg_sel;
  logic          port_ok;

  assign port_sel = addr[ADDR_W-1:3];
  assign reg_sel  = addr[2:0];
  assign port_ok  = 32'(port_sel) < N_PORTS;

  logic [WIDTH-1:0] dir_q      [N_PORTS];
  logic [WIDTH-1:0] dir_d      [N_PORTS];
  logic [WIDTH-1:0] out_q      [N_PORTS];
  logic [WIDTH-1:0] out_d      [N_PORTS];
  logic [WIDTH-1:0] ie_q       [N_PORTS];
  logic [WIDTH-1:0] ie_d       [N_PORTS];
  logic [WIDTH-1:0] is_q       [N_PORTS];
  logic [WIDTH-1:0] is_d       [N_PORTS];
  logic [WIDTH-1:0] edge_sel_q [N_PORTS];
  logic [WIDTH-1:0] edge_sel_d [N_PORTS];
  logic [WIDTH-1:0] hist_q     [N_PORTS];
  logic [WIDTH-1:0] hist_d     [N_PORTS];
  logic [WIDTH-1:0] sync_q     [N_PORTS][SYNC_STAGES];
  logic [WIDTH-1:0] sync_d     [N_PORTS][SYNC_STAGES];

  logic [WIDTH-1:0] pin_s      [N_PORTS];
  logic [WIDTH-1:0] evt        [N_PORTS];
  logic [N_PORTS-1:0] wr_hit;

  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             irq_q, irq_d;

  // Edge events: history holds the previous synchroniser output.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      pin_s[p]  = sync_q[p][SYNC_STAGES-1];
      evt[p]    = (edge_sel_q[p] & ~pin_s[p] & hist_q[p]) |
                  (~edge_sel_q[p] & pin_s[p] & ~hist_q[p]);
      wr_hit[p] = wr_en && port_ok && (port_sel == PW'(p));
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      dir_d[p]      = dir_q[p];
      out_d[p]      = out_q[p];
      ie_d[p]       = ie_q[p];
      is_d[p]       = is_q[p];
      edge_sel_d[p] = edge_sel_q[p];
      hist_d[p]     = pin_s[p];
      sync_d[p][0]  = gpio_in[p*WIDTH +: WIDTH];
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_d[p][s] = sync_q[p][s-1];
      end
      if (wr_hit[p]) begin
        case (reg_sel)
          RegDir:  dir_d[p]      = wdata;
          RegOut:  out_d[p]      = wdata;
          RegIe:   ie_d[p]       = wdata;
          RegIs:   is_d[p]       = is_q[p] & ~wdata;
          RegEdge: edge_sel_d[p] = wdata;
          default: ;
        endcase
      end
      // A new edge overrides a simultaneous W1C on the same bit.
      is_d[p] = is_d[p] | evt[p];
    end
  end

  always_comb begin
    rd_val = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (port_sel == PW'(p)) begin
        case (reg_sel)
          RegDir:  rd_val = dir_q[p];
          RegOut:  rd_val = out_q[p];
          RegIn:   rd_val = pin_s[p];
          RegIe:   rd_val = ie_q[p];
          RegIs:   rd_val = is_q[p];
          RegEdge: rd_val = edge_sel_q[p];
          default: rd_val = '0;
        endcase
      end
    end
    rdata_d  = rd_en ? rd_val : rdata_q;
    rvalid_d = rd_en;
  end

  always_comb begin
    irq_d = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      irq_d = irq_d | (|(is_q[p] & ie_q[p]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < N_PORTS; p++) begin
        dir_q[p]      <= '0;
        out_q[p]      <= '0;
        ie_q[p]       <= '0;
        is_q[p]       <= '0;
        edge_sel_q[p] <= '0;
        hist_q[p]     <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[p][s] <= '0;
        end
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        dir_q[p]      <= dir_d[p];
        out_q[p]      <= out_d[p];
        ie_q[p]       <= ie_d[p];
        is_q[p]       <= is_d[p];
        edge_sel_q[p] <= edge_sel_d[p];
        hist_q[p]     <= hist_d[p];
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_q[p][s] <= sync_d[p][s];
        end
      end
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_pins
    assign gpio_out[g*WIDTH +: WIDTH] = out_q[g];
    assign gpio_oe[g*WIDTH +: WIDTH]  = dir_q[g];
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: expected read data is queued when a read is issued and
// popped when rvalid is sampled.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [23:0] gpio_in;
  logic [23:0] gpio_out;
  logic [23:0] gpio_oe;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got;

  gpio_bank #(
    .N_PORTS(3), .WIDTH(8), .ADDR_W(5), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e);
    addr = a; rd_en = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; gpio_in = '0;
    tick(2);
    reset = 1'b1;
    tick(1);
    n_checks++;
    if (gpio_oe !== 24'h0 || gpio_out !== 24'h0 || irq !== 1'b0 || rvalid !== 1'b0)
      $display("FAIL reset_outputs: oe=%h out=%h irq=%b rvalid=%b, want all 0",
               gpio_oe, gpio_out, irq, rvalid);
    else n_pass++;
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 8; r++) begin
        rd(5'(p * 8 + r), 8'h00);
        got = exp_q.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== got)
          $display("FAIL reset_read p%0d r%0d: rvalid=%b rdata=%h, want 1/%h",
                   p, r, rvalid, rdata, got);
        else n_pass++;
      end
    end
    tick(1);
    n_checks++;
    if (rvalid !== 1'b0) $display("FAIL rvalid_pulse: rvalid=%b, want 0", rvalid);
    else n_pass++;
  endtask

  task automatic test_dir_out_in;
    wr(5'h08, 8'hF0);
    wr(5'h09, 8'hA5);
    n_checks++;
    if (gpio_oe !== 24'h00F000 || gpio_out !== 24'h00A500)
      $display("FAIL dir_out: oe=%h out=%h, want 00f000/00a500", gpio_oe, gpio_out);
    else n_pass++;
    gpio_in[15:8] = 8'h0F;
    tick(3);
    rd(5'h0A, 8'h0F);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got)
      $display("FAIL in_read: rvalid=%b rdata=%h, want 1/%h", rvalid, rdata, got);
    else n_pass++;
    tick(1);
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 8'h0F)
      $display("FAIL rdata_hold: rvalid=%b rdata=%h, want 0/0f", rvalid, rdata);
    else n_pass++;
    // Simultaneous read and write returns the pre-write value.
    addr = 5'h09; wdata = 8'h3C; wr_en = 1'b1; rd_en = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got || gpio_out[15:8] !== 8'h3C)
      $display("FAIL rd_wr_same: rdata=%h out=%h, want %h/3c", rdata, gpio_out[15:8], got);
    else n_pass++;
  endtask

  task automatic test_irq_rise;
    wr(5'h05, 8'h00);
    wr(5'h03, 8'h01);
    gpio_in[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (irq !== (i == 4))
        $display("FAIL irq_latency edge%0d: irq=%b, want %b", i - 1, irq, (i == 4));
      else n_pass++;
    end
    rd(5'h04, 8'h01);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got)
      $display("FAIL is_rise: rvalid=%b rdata=%h, want 1/%h", rvalid, rdata, got);
    else n_pass++;
    wr(5'h04, 8'h01);
    tick(1);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL w1c_irq: irq=%b, want 0", irq);
    else n_pass++;
  endtask

  task automatic test_edge_fall;
    wr(5'h15, 8'h80);
    wr(5'h13, 8'h80);
    gpio_in[23] = 1'b1;
    tick(4);
    rd(5'h14, 8'h00);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got || irq !== 1'b0)
      $display("FAIL fall_ignores_rise: rdata=%h irq=%b, want %h/0", rdata, irq, got);
    else n_pass++;
    gpio_in[23] = 1'b0;
    tick(4);
    rd(5'h14, 8'h80);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got || irq !== 1'b1)
      $display("FAIL fall_sets: rdata=%h irq=%b, want %h/1", rdata, irq, got);
    else n_pass++;
    gpio_in[23] = 1'b1;
    tick(4);
    wr(5'h15, 8'h00);
    rd(5'h14, 8'h80);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got)
      $display("FAIL is_sticky: rdata=%h, want %h", rdata, got);
    else n_pass++;
    wr(5'h14, 8'h80);
    tick(2);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL p2_clear_irq: irq=%b, want 0", irq);
    else n_pass++;
  endtask

  task automatic test_w1c_collision;
    gpio_in[0] = 1'b0;
    tick(4);
    gpio_in[0] = 1'b1;
    tick(4);
    gpio_in[0] = 1'b0;
    tick(4);
    gpio_in[0] = 1'b1;
    tick(2);
    wr(5'h04, 8'h01);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (irq !== 1'b1) $display("FAIL collision_irq c%0d: irq=%b, want 1", i, irq);
      else n_pass++;
      @(negedge clk);
    end
    rd(5'h04, 8'h01);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got)
      $display("FAIL collision_is: rdata=%h, want %h", rdata, got);
    else n_pass++;
    wr(5'h04, 8'h01);
    tick(2);
  endtask

  task automatic test_bad_port_and_reset;
    wr(5'h18, 8'hFF);
    wr(5'h19, 8'hFF);
    wr(5'h1B, 8'hFF);
    wr(5'h06, 8'hFF);
    n_checks++;
    if (gpio_oe !== 24'h00F000 || gpio_out !== 24'h003C00 || irq !== 1'b0)
      $display("FAIL bad_port_write: oe=%h out=%h irq=%b, want 00f000/003c00/0",
               gpio_oe, gpio_out, irq);
    else n_pass++;
    rd(5'h18, 8'h00);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got)
      $display("FAIL bad_port_read: rvalid=%b rdata=%h, want 1/%h", rvalid, rdata, got);
    else n_pass++;
    rd(5'h06, 8'h00);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got)
      $display("FAIL reserved_read: rvalid=%b rdata=%h, want 1/%h", rvalid, rdata, got);
    else n_pass++;
    // Reset lands between the read request and its clock edge.
    addr = 5'h08; rd_en = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0 || gpio_oe !== 24'h0)
      $display("FAIL reset_mid_read: rvalid=%b oe=%h, want 0/0", rvalid, gpio_oe);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b0) $display("FAIL rvalid_dropped c%0d: rvalid=%b, want 0", i, rvalid);
      else n_pass++;
    end
    rd(5'h0C, 8'h0F);
    got = exp_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== got)
      $display("FAIL post_reset_rise: rdata=%h, want %h", rdata, got);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_dir_out_in();
    test_irq_rise();
    test_edge_fall();
    test_w1c_collision();
    test_bad_port_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
